// File: rtl/branch_pkg.sv
// Shared types and helpers for branch resolution: queue entry layout and mispredict compare.
// Pure declarations; no latency or backpressure of its own.
package branch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSN_BYTES   = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic                    pred_taken;
        logic [XLEN_DEFAULT-1:0] pred_target;
    } bq_entry_t;

    // A correct direction with a wrong taken target is still a mispredict.
    function automatic logic is_mispredict(input bq_entry_t entry,
                                           input logic taken,
                                           input logic [XLEN_DEFAULT-1:0] target);
        return (taken != entry.pred_taken) ||
               (taken && entry.pred_taken && (target != entry.pred_target));
    endfunction

endpackage

// File: rtl/bq_fifo.sv
// Circular buffer of in-flight branches with push/pop/clear; head visible combinationally.
// Latency 1 cycle push-to-head; pushes while full are dropped, clear wins over push.
module bq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
            rptr  <= wptr;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions against EX, drives predictor update, flush and redirect.
// Outputs registered (resolve in N -> pulses in N+1); bq_full stalls decode. Option: BR_PERF_CNT_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bq_push,
    input  logic [XLEN-1:0] bq_pc,
    input  logic            bq_pred_taken,
    input  logic [XLEN-1:0] bq_pred_target,
    output logic            bq_full,
    output logic            bq_empty,
    input  logic            ex_valid,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            branch_ins,
    output logic            predict_failed,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            resolve_err
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0]     perf_br_total,
    output logic [31:0]     perf_br_miss
`endif
);

    bq_entry_t       push_entry;
    bq_entry_t       head;
    logic            resolve;
    logic            mispred;
    logic [XLEN-1:0] correct_pc;

    assign push_entry.pc          = bq_pc;
    assign push_entry.pred_taken  = bq_pred_taken;
    assign push_entry.pred_target = bq_pred_target;

    assign resolve    = ex_valid && !bq_empty;
    assign mispred    = resolve && is_mispredict(head, ex_taken, ex_target);
    assign correct_pc = ex_taken ? ex_target : head.pc + XLEN'(INSN_BYTES);

    // A mispredict clears the queue, which also discards any same-cycle wrong-path push.
    bq_fifo #(
        .W     ($bits(bq_entry_t)),
        .DEPTH (DEPTH)
    ) u_bq_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bq_push),
        .pop   (resolve),
        .clear (mispred),
        .din   (push_entry),
        .dout  (head),
        .full  (bq_full),
        .empty (bq_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_ins     <= 1'b0;
            predict_failed <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            resolve_err    <= 1'b0;
        end else begin
            branch_ins     <= resolve;
            predict_failed <= mispred;
            flush          <= mispred;
            redirect_pc    <= mispred ? correct_pc : '0;
            if (ex_valid && bq_empty) resolve_err <= 1'b1;
        end
    end

`ifdef BR_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_br_total <= '0;
            perf_br_miss  <= '0;
        end else begin
            if (branch_ins && (perf_br_total != '1))    perf_br_total <= perf_br_total + 32'd1;
            if (predict_failed && (perf_br_miss != '1)) perf_br_miss  <= perf_br_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue model and an expected-pulse scoreboard.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bq_push;
    logic [31:0] bq_pc;
    logic        bq_pred_taken;
    logic [31:0] bq_pred_target;
    logic        bq_full;
    logic        bq_empty;
    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        branch_ins;
    logic        predict_failed;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        resolve_err;
`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_br_total;
    logic [31:0] perf_br_miss;
`endif

    branch_resolve_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bq_push        (bq_push),
        .bq_pc          (bq_pc),
        .bq_pred_taken  (bq_pred_taken),
        .bq_pred_target (bq_pred_target),
        .bq_full        (bq_full),
        .bq_empty       (bq_empty),
        .ex_valid       (ex_valid),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .branch_ins     (branch_ins),
        .predict_failed (predict_failed),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .resolve_err    (resolve_err)
`ifdef BR_PERF_CNT_EN
        ,
        .perf_br_total  (perf_br_total),
        .perf_br_miss   (perf_br_miss)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic [31:0] tgt;
    } m_ent_t;

    typedef struct {
        logic        bi;
        logic        pf;
        logic        fl;
        logic [31:0] rpc;
        logic        err;
    } exp_t;

    m_ent_t mq[$];
    exp_t   exp_q[$];
    logic   m_err;
    int     m_total;
    int     m_miss;
    int     checks;
    int     failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle; model predicts the registered outputs visible after the edge.
    task automatic step(input logic p, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptgt, input logic ev, input logic et,
                        input logic [31:0] etgt);
        exp_t   e;
        exp_t   got;
        m_ent_t h;
        logic   res;
        logic   mis;
        logic   was_full;
        logic   was_empty;
        @(negedge clk);
        bq_push = p; bq_pc = pc; bq_pred_taken = pt; bq_pred_target = ptgt;
        ex_valid = ev; ex_taken = et; ex_target = etgt;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        res = ev && !was_empty;
        mis = 1'b0;
        e.rpc = 32'h0;
        if (res) begin
            h = mq.pop_front();
            mis = (et != h.t) || (et && h.t && (etgt != h.tgt));
            e.rpc = et ? etgt : h.pc + 32'd4;
        end
        if (mis) mq.delete();
        else if (p && !was_full) mq.push_back('{pc, pt, ptgt});
        if (ev && was_empty) m_err = 1'b1;
        e.bi = res; e.pf = mis; e.fl = mis; e.err = m_err;
        if (res) m_total++;
        if (mis) m_miss++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("branch_ins", 64'(branch_ins), 64'(got.bi));
        chk("predict_failed", 64'(predict_failed), 64'(got.pf));
        chk("flush", 64'(flush), 64'(got.fl));
        if (got.fl) chk("redirect_pc", 64'(redirect_pc), 64'(got.rpc));
        chk("resolve_err", 64'(resolve_err), 64'(got.err));
        chk("bq_empty", 64'(bq_empty), 64'(mq.size() == 0));
        chk("bq_full", 64'(bq_full), 64'(mq.size() == DEPTH));
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bq_push = 1'b0; ex_valid = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        exp_q.delete();
        m_err = 1'b0; m_total = 0; m_miss = 0;
        chk("rst_branch_ins", 64'(branch_ins), 64'd0);
        chk("rst_predict_failed", 64'(predict_failed), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_resolve_err", 64'(resolve_err), 64'd0);
        chk("rst_bq_empty", 64'(bq_empty), 64'd1);
        chk("rst_bq_full", 64'(bq_full), 64'd0);
`ifdef BR_PERF_CNT_EN
        chk("rst_perf_total", 64'(perf_br_total), 64'd0);
        chk("rst_perf_miss", 64'(perf_br_miss), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_err = 1'b0; m_total = 0; m_miss = 0;
        rst_n = 1'b0;
        bq_push = 1'b0; bq_pc = '0; bq_pred_taken = 1'b0; bq_pred_target = '0;
        ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
        do_reset();

        // Correct prediction
        step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        idle();

        // Predicted not-taken, actually taken
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h180);
        idle();

        // Predicted taken, actually not taken -> fall-through
        step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle();

        // Fill, overflow push, push+correct resolve while full, then mispredict with push
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h110, 1'b1, 32'h210, 1'b1, 1'b1, 32'h200);
        step(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        idle();

        // Right direction, wrong target
        step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        idle();

        // Back-to-back resolves with a push+resolve that keeps the count
        step(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h144, 1'b1, 32'h250, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h148, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h250);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle();
        idle();
`ifdef BR_PERF_CNT_EN
        chk("perf_total", 64'(perf_br_total), 64'(m_total));
        chk("perf_miss", 64'(perf_br_miss), 64'(m_miss));
`endif

        // Resolve with empty queue: sticky error, no pulses
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
        idle();

        // Mid-stream reset with entries in flight and error set
        step(1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h704, 1'b0, 32'h0, 1'b1, 1'b1, 32'h800);
        do_reset();
        idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
